// File: rtl/ct_had_ddc_ctrl_pkg.sv
// Shared HAD DDC definitions: FSM state encodings, address increment, timeout width default.
package ct_had_ddc_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'b000,
        StAddrLd = 3'b001,
        StAddrEx = 3'b010,
        StDataLd = 3'b011,
        StDataEx = 3'b100,
        StStLd   = 3'b101,
        StStEx   = 3'b110
    } ddc_state_e;

    localparam int unsigned DdcAddrInc = 8;
    localparam int unsigned DdcTmoW    = 10;

endpackage

// File: rtl/ct_had_ddc_ctrl_if.sv
// DDC control bundle: JTAG/CSR/execution-control inputs and datapath/IR strobes.
interface ct_had_ddc_ctrl_if;

    logic x_sm_xx_update_dr_en;
    logic ir_xx_daddr_reg_sel;
    logic ir_xx_ddata_reg_sel;
    logic regs_ddc_en;
    logic ctrl_ddc_dbg_mode;
    logic ctrl_ddc_inst_done;
    logic ddc_ctrl_dp_addr_sel;
    logic ddc_ctrl_dp_data_sel;
    logic ddc_ctrl_dp_addr_gen;
    logic ddc_ctrl_inst_req;
    logic ddc_ctrl_busy;
    logic ddc_ctrl_err;

    modport master (
        input  x_sm_xx_update_dr_en, ir_xx_daddr_reg_sel, ir_xx_ddata_reg_sel,
        input  regs_ddc_en, ctrl_ddc_dbg_mode, ctrl_ddc_inst_done,
        output ddc_ctrl_dp_addr_sel, ddc_ctrl_dp_data_sel, ddc_ctrl_dp_addr_gen,
        output ddc_ctrl_inst_req, ddc_ctrl_busy, ddc_ctrl_err
    );

    modport slave (
        output x_sm_xx_update_dr_en, ir_xx_daddr_reg_sel, ir_xx_ddata_reg_sel,
        output regs_ddc_en, ctrl_ddc_dbg_mode, ctrl_ddc_inst_done,
        input  ddc_ctrl_dp_addr_sel, ddc_ctrl_dp_data_sel, ddc_ctrl_dp_addr_gen,
        input  ddc_ctrl_inst_req, ddc_ctrl_busy, ddc_ctrl_err
    );

endinterface

// File: rtl/ct_had_ddc_tmo.sv
// Per-instruction timeout counter for the DDC FSM; used only under HAD_DDC_TIMEOUT_EN.
module ct_had_ddc_tmo
    import ct_had_ddc_ctrl_pkg::*;
#(
    parameter int unsigned TMO_W = DdcTmoW
) (
    input  logic cpuclk,
    input  logic cpurst_b,
    input  logic in_ex,
    output logic expire
);

    logic [TMO_W-1:0] cnt_q;

    // Every *_EX is entered from a *_LD cycle, so holding zero outside EX clears it on entry.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cnt_q <= '0;
        end else if (!in_ex) begin
            cnt_q <= '0;
        end else if (!expire) begin
            cnt_q <= cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
    end

    assign expire = in_ex & (&cnt_q);

endmodule

// File: rtl/ct_had_ddc_ctrl.sv
// HAD DDC control FSM: turns each DDATA update into mv x1 / mv x2 / sd injections.
// Optional per-instruction timeout abort under HAD_DDC_TIMEOUT_EN.
module ct_had_ddc_ctrl
    import ct_had_ddc_ctrl_pkg::*;
#(
    parameter int unsigned TMO_W = DdcTmoW
) (
    input  logic              cpuclk,
    input  logic              cpurst_b,
    ct_had_ddc_ctrl_if.master ddc
);

    ddc_state_e state_q, state_d;
    logic       start_q, start_d;
    logic       addr_new_q, addr_new_d;
    logic       err_q, err_d;
    logic       en_ok, daddr_wr, ddata_wr, dbg, done;
    logic       busy, in_ex, in_ld, abort, addr_gen, tmo_expire;

    if (TMO_W < 2) begin : g_tmo_w_chk
        $error("ct_had_ddc_ctrl: TMO_W must be at least 2");
    end

    assign dbg   = ddc.ctrl_ddc_dbg_mode;
    assign done  = ddc.ctrl_ddc_inst_done;
    assign en_ok = ddc.regs_ddc_en & dbg;

    // DADDR wins if both selects are somehow asserted.
    assign daddr_wr = ddc.x_sm_xx_update_dr_en & ddc.ir_xx_daddr_reg_sel & en_ok;
    assign ddata_wr = ddc.x_sm_xx_update_dr_en & ddc.ir_xx_ddata_reg_sel & en_ok
                    & ~ddc.ir_xx_daddr_reg_sel;

    assign busy  = (state_q != StIdle) | start_q;
    assign in_ex = state_q inside {StAddrEx, StDataEx, StStEx};
    assign in_ld = state_q inside {StAddrLd, StDataLd, StStLd};

`ifdef HAD_DDC_TIMEOUT_EN
    ct_had_ddc_tmo #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .cpuclk   (cpuclk),
        .cpurst_b (cpurst_b),
        .in_ex    (in_ex),
        .expire   (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        addr_new_d = addr_new_q;
        err_d      = err_q;
        addr_gen   = 1'b0;
        abort      = 1'b0;

        // Start request cycle lets the datapath registers settle before the first LD.
        if (start_q) begin
            start_d = 1'b0;
            if (!dbg) begin
                abort = 1'b1;
            end else begin
                state_d = addr_new_q ? StAddrLd : StDataLd;
            end
        end

        unique case (state_q)
            StIdle:   if (ddata_wr && !start_q) start_d = 1'b1;
            StAddrLd: state_d = StAddrEx;
            StAddrEx: begin
                if (done) begin
                    state_d    = StDataLd;
                    addr_new_d = 1'b0;
                end
            end
            StDataLd: state_d = StDataEx;
            StDataEx: if (done) state_d = StStLd;
            StStLd:   state_d = StStEx;
            StStEx: begin
                if (done) begin
                    state_d  = StIdle;
                    addr_gen = 1'b1;
                end
            end
            default:  state_d = StIdle;
        endcase

        // A done in the same cycle as an expiry still completes the instruction.
        if (state_q != StIdle && (!dbg || (tmo_expire && !done))) begin
            abort    = 1'b1;
            state_d  = StIdle;
            addr_gen = 1'b0;
        end

        if (abort) begin
            err_d      = 1'b1;
            addr_new_d = 1'b1;
        end

        if (daddr_wr) begin
            addr_new_d = 1'b1;
            err_d      = busy;
        end

        if (ddata_wr && busy) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            addr_new_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            addr_new_q <= addr_new_d;
            err_q      <= err_d;
        end
    end

    assign ddc.ddc_ctrl_dp_addr_sel = state_q inside {StAddrLd, StAddrEx};
    assign ddc.ddc_ctrl_dp_data_sel = state_q inside {StDataLd, StDataEx};
    assign ddc.ddc_ctrl_dp_addr_gen = addr_gen;
    assign ddc.ddc_ctrl_inst_req    = in_ld;
    assign ddc.ddc_ctrl_busy        = busy;
    assign ddc.ddc_ctrl_err         = err_q;

endmodule

// File: tb/tb_ct_had_ddc_ctrl.sv
// Directed bench for ct_had_ddc_ctrl: cycle vector table plus transfer/reset sequences.
module tb_ct_had_ddc_ctrl;

    logic        cpuclk = 1'b0;
    logic        cpurst_b;
    logic [63:0] dp_daddr;
    logic [63:0] dp_wdata;
    logic [5:0]  outs;
    int          errors = 0;
    int          checks = 0;

    ct_had_ddc_ctrl_if bus ();

    ct_had_ddc_ctrl #(
        .TMO_W (10)
    ) u_dut (
        .cpuclk   (cpuclk),
        .cpurst_b (cpurst_b),
        .ddc      (bus)
    );

    always #5 cpuclk = ~cpuclk;

    assign outs = {bus.ddc_ctrl_dp_addr_sel, bus.ddc_ctrl_dp_data_sel, bus.ddc_ctrl_dp_addr_gen,
                   bus.ddc_ctrl_inst_req, bus.ddc_ctrl_busy, bus.ddc_ctrl_err};

    // Minimal DADDR register of the downstream datapath.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            dp_daddr <= 64'd0;
        end else if (bus.x_sm_xx_update_dr_en && bus.ir_xx_daddr_reg_sel && bus.regs_ddc_en
                     && bus.ctrl_ddc_dbg_mode) begin
            dp_daddr <= dp_wdata;
        end else if (bus.ddc_ctrl_dp_addr_gen) begin
            dp_daddr <= dp_daddr + 64'd8;
        end
    end

    // in  = {update_dr, daddr_sel, ddata_sel, ddc_en, dbg_mode, inst_done}
    // exp = {addr_sel, data_sel, addr_gen, inst_req, busy, err}
    // daddr: write data on a DADDR write, otherwise expected DADDR when nonzero
    typedef struct {
        logic [5:0]  in;
        logic [5:0]  exp;
        logic [63:0] daddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [5:0] i, logic [5:0] e, logic [63:0] d);
        vec_t v;
        v.in    = i;
        v.exp   = e;
        v.daddr = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {bus.x_sm_xx_update_dr_en, bus.ir_xx_daddr_reg_sel, bus.ir_xx_ddata_reg_sel,
         bus.regs_ddc_en, bus.ctrl_ddc_dbg_mode, bus.ctrl_ddc_inst_done} = in;
    endtask

    // Issues a DDATA write and answers each inst_req with done in the following cycle.
    // Returns at the negedge of the first cycle in which busy reads 0.
    task automatic xfer(input bit drop_en, output int nreq, output int ngen, output int ncyc,
                        output bit ok);
        bit pend;
        nreq = 0; ngen = 0; ncyc = 0; ok = 1'b0; pend = 1'b0;
        bus.x_sm_xx_update_dr_en = 1'b1;
        bus.ir_xx_ddata_reg_sel  = 1'b1;
        @(posedge cpuclk); #1;
        bus.x_sm_xx_update_dr_en = 1'b0;
        bus.ir_xx_ddata_reg_sel  = 1'b0;
        if (drop_en) bus.regs_ddc_en = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.ctrl_ddc_inst_done = pend;
            pend = 1'b0;
            @(negedge cpuclk);
            if (!bus.ddc_ctrl_busy) begin
                ok = 1'b1;
                break;
            end
            ncyc++;
            if (bus.ddc_ctrl_inst_req) begin
                nreq++;
                pend = 1'b1;
            end
            if (bus.ddc_ctrl_dp_addr_gen) ngen++;
            @(posedge cpuclk); #1;
        end
        bus.ctrl_ddc_inst_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq, ngen, ncyc;
        bit ok;

        tbl.push_back(mk(6'b110110, 6'b000000, 64'h8000_0000));  // DADDR write
        tbl.push_back(mk(6'b101110, 6'b000000, 64'h8000_0000));  // DDATA write
        tbl.push_back(mk(6'b000110, 6'b000010, 64'h0));          // start request
        tbl.push_back(mk(6'b000110, 6'b100110, 64'h0));          // ADDR_LD
        tbl.push_back(mk(6'b000111, 6'b100010, 64'h0));          // ADDR_EX done
        tbl.push_back(mk(6'b000110, 6'b010110, 64'h0));          // DATA_LD
        tbl.push_back(mk(6'b000111, 6'b010010, 64'h0));          // DATA_EX done
        tbl.push_back(mk(6'b000110, 6'b000110, 64'h0));          // ST_LD
        tbl.push_back(mk(6'b000111, 6'b001010, 64'h0));          // ST_EX done, addr_gen
        tbl.push_back(mk(6'b000110, 6'b000000, 64'h8000_0008));
        tbl.push_back(mk(6'b101110, 6'b000000, 64'h0));          // DDATA, no new DADDR
        tbl.push_back(mk(6'b000110, 6'b000010, 64'h0));
        tbl.push_back(mk(6'b000111, 6'b010110, 64'h0));          // done in LD ignored
        tbl.push_back(mk(6'b000111, 6'b010010, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b000110, 64'h0));
        tbl.push_back(mk(6'b000111, 6'b001010, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b000000, 64'h8000_0010));
        tbl.push_back(mk(6'b101110, 6'b000000, 64'h0));          // overrun sequence
        tbl.push_back(mk(6'b000110, 6'b000010, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b010110, 64'h0));
        tbl.push_back(mk(6'b101110, 6'b010010, 64'h0));          // DDATA in DATA_EX
        tbl.push_back(mk(6'b000111, 6'b010011, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b000111, 64'h0));
        tbl.push_back(mk(6'b000111, 6'b001011, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b000001, 64'h8000_0018));
        tbl.push_back(mk(6'b110110, 6'b000001, 64'h9000_0000));  // DADDR clears err
        tbl.push_back(mk(6'b000110, 6'b000000, 64'h9000_0000));
        tbl.push_back(mk(6'b101110, 6'b000000, 64'h0));          // abort sequence
        tbl.push_back(mk(6'b000110, 6'b000010, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b100110, 64'h0));
        tbl.push_back(mk(6'b000111, 6'b100010, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b010110, 64'h0));
        tbl.push_back(mk(6'b000111, 6'b010010, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b000110, 64'h0));
        tbl.push_back(mk(6'b000100, 6'b000010, 64'h0));          // dbg_mode drops in ST_EX
        tbl.push_back(mk(6'b000110, 6'b000001, 64'h9000_0000));  // IDLE, no addr_gen
        tbl.push_back(mk(6'b101110, 6'b000001, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b000011, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b100111, 64'h0));          // restarts with ADDR_LD
        tbl.push_back(mk(6'b000111, 6'b100011, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b010111, 64'h0));
        tbl.push_back(mk(6'b000111, 6'b010011, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b000111, 64'h0));
        tbl.push_back(mk(6'b000111, 6'b001011, 64'h0));
        tbl.push_back(mk(6'b000110, 6'b000001, 64'h9000_0008));
        tbl.push_back(mk(6'b111110, 6'b000001, 64'hA000_0000));  // both selects: DADDR wins
        tbl.push_back(mk(6'b000110, 6'b000000, 64'hA000_0000));
        tbl.push_back(mk(6'b000110, 6'b000000, 64'h0));
        tbl.push_back(mk(6'b000111, 6'b000000, 64'h0));          // done in IDLE ignored
        tbl.push_back(mk(6'b101010, 6'b000000, 64'h0));          // DDATA with ddc_en = 0
        tbl.push_back(mk(6'b000110, 6'b000000, 64'hA000_0000));

        cpurst_b = 1'b1;
        dp_wdata = 64'd0;
        drive(6'b000000);
        #1 cpurst_b = 1'b0;
        #2 chk("reset_outs", 64'(outs), 64'd0);
        repeat (2) @(posedge cpuclk);
        @(negedge cpuclk);
        cpurst_b = 1'b1;
        @(posedge cpuclk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in);
            dp_wdata = tbl[i].daddr;
            @(negedge cpuclk);
            chk($sformatf("vec%0d_outs", i), 64'(outs), 64'(tbl[i].exp));
            if (!(tbl[i].in[5] && tbl[i].in[4]) && tbl[i].daddr != 64'd0) begin
                chk($sformatf("vec%0d_daddr", i), dp_daddr, tbl[i].daddr);
            end
            @(posedge cpuclk); #1;
        end
        drive(6'b000110);

        // Back-to-back: second DDATA issued in the first cycle busy reads 0.
        xfer(1'b0, nreq, ngen, ncyc, ok);
        chk("b2b1_done", 64'(ok), 64'd1);
        chk("b2b1_nreq", 64'(nreq), 64'd3);
        chk("b2b1_ngen", 64'(ngen), 64'd1);
        chk("b2b1_ncyc", 64'(ncyc), 64'd7);
        xfer(1'b0, nreq, ngen, ncyc, ok);
        chk("b2b2_done", 64'(ok), 64'd1);
        chk("b2b2_nreq", 64'(nreq), 64'd2);
        chk("b2b2_ngen", 64'(ngen), 64'd1);
        chk("b2b2_ncyc", 64'(ncyc), 64'd5);
        chk("b2b2_err", 64'(bus.ddc_ctrl_err), 64'd0);
        chk("b2b2_daddr", dp_daddr, 64'hA000_0010);

        // Clearing ddc_en mid-sequence must not abort.
        xfer(1'b1, nreq, ngen, ncyc, ok);
        chk("en_drop_done", 64'(ok), 64'd1);
        chk("en_drop_nreq", 64'(nreq), 64'd2);
        chk("en_drop_ngen", 64'(ngen), 64'd1);
        chk("en_drop_err", 64'(bus.ddc_ctrl_err), 64'd0);
        chk("en_drop_daddr", dp_daddr, 64'hA000_0018);
        bus.regs_ddc_en = 1'b1;

        // Asynchronous reset while in DATA_EX.
        @(posedge cpuclk); #1;
        bus.x_sm_xx_update_dr_en = 1'b1;
        bus.ir_xx_ddata_reg_sel  = 1'b1;
        @(posedge cpuclk); #1;
        bus.x_sm_xx_update_dr_en = 1'b0;
        bus.ir_xx_ddata_reg_sel  = 1'b0;
        repeat (2) begin
            @(posedge cpuclk); #1;
        end
        @(negedge cpuclk);
        chk("rst_pre_outs", 64'(outs), 64'b010010);
        #2 cpurst_b = 1'b0;
        #1 chk("rst_async_outs", 64'(outs), 64'd0);
        #1 cpurst_b = 1'b1;
        @(negedge cpuclk);
        chk("rst_post_outs", 64'(outs), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ct_had_ddc_ctrl.md
# ct_had_ddc_ctrl

Control FSM of the HAD debug download channel (DDC). Sits directly upstream of the DDC datapath and drives its address-select, data-select and address-increment strobes. Each JTAG DDATA update becomes a three-instruction sequence injected into the core through the HAD instruction register: mv x1 (address), mv x2 (data), sd x2,0(x1). Handshakes with the HAD execution control for each injected instruction and flags overruns and aborts.

## Interface
Parameters:
- TMO_W, 10, width of the per-instruction timeout counter; used only with HAD_DDC_TIMEOUT_EN.

Ports:
- cpuclk  in  1  core clock; the block's only clock.
- cpurst_b  in  1  asynchronous, active-low reset.
- x_sm_xx_update_dr_en  in  1  JTAG Update-DR pulse, already synchronised to cpuclk.
- ir_xx_daddr_reg_sel  in  1  DADDR selected by the JTAG IR.
- ir_xx_ddata_reg_sel  in  1  DDATA selected by the JTAG IR.
- regs_ddc_en  in  1  DDC enable bit from the HAD CSR.
- ctrl_ddc_dbg_mode  in  1  core is in debug mode.
- ctrl_ddc_inst_done  in  1  injected instruction retired; one-cycle pulse.
- ddc_ctrl_dp_addr_sel  out  1  datapath presents the address and mv x1.
- ddc_ctrl_dp_data_sel  out  1  datapath presents the data and mv x2.
- ddc_ctrl_dp_addr_gen  out  1  one-cycle pulse; datapath adds 8 to DADDR.
- ddc_ctrl_inst_req  out  1  one-cycle pulse; load the IR from the datapath and execute.
- ddc_ctrl_busy  out  1  a sequence is in flight.
- ddc_ctrl_err  out  1  sticky error flag.

## Operation
- Clock and reset: single clock cpuclk. Reset is asynchronous and active-low on cpurst_b.
- Trigger conditions:
  - daddr_wr = update_dr_en & daddr_reg_sel.
  - ddata_wr = update_dr_en & ddata_reg_sel.
  - Both are ignored when regs_ddc_en = 0 or ctrl_ddc_dbg_mode = 0.
- addr_new flag:
  - Set on daddr_wr.
  - Cleared on the ADDR_EX done.
  - A daddr_wr also clears err.
- States: IDLE, ADDR_LD, ADDR_EX, DATA_LD, DATA_EX, ST_LD, ST_EX.
- Transitions:
  - IDLE: ddata_wr latches a start request. Next cycle, go to ADDR_LD if addr_new = 1, else DATA_LD. The one-cycle delay lets the datapath registers settle.
  - Every *_LD state lasts exactly one cycle, asserts inst_req, then goes to its *_EX state.
  - ADDR_EX waits for done, then goes to DATA_LD.
  - DATA_EX waits for done, then goes to ST_LD.
  - ST_EX waits for done, pulses addr_gen in that same cycle, then goes to IDLE.
- Select outputs:
  - addr_sel = 1 in ADDR_LD/ADDR_EX.
  - data_sel = 1 in DATA_LD/DATA_EX.
  - Both are 0 in ST_* and IDLE.
  - The selects are decoded from registered state only, so they are stable for the whole LD+EX window.
- busy = 1 in any state other than IDLE, and also in the start-request cycle.
- Overrun: a ddata_wr while busy sets err. The sequence continues; the stored data may be torn, which software detects through err.
- A daddr_wr while busy sets err and addr_new. The current sequence finishes with whatever address the datapath now holds.
- Abort: ctrl_ddc_dbg_mode falling in any non-IDLE state causes:
  - immediate return to IDLE,
  - err set,
  - addr_new set, so the next transfer reloads x1,
  - no addr_gen pulse.
- Clearing regs_ddc_en mid-sequence does not abort. It only blocks new starts.
- A done pulse is honoured only in *_EX states. A done in IDLE or *_LD is ignored.

## Timing
- Reset values: state = IDLE, addr_new = 0, err = 0. All outputs are 0.
- Latency, ddata_wr to first inst_req: 2 cycles.
- Minimum sequence length:
  - With address: 8 cycles if each done arrives the cycle after its inst_req.
  - Without address: 6 cycles.
- addr_gen coincides with the ST_EX done cycle. DADDR reflects +8 on the following edge.
- Back-to-back transfers: the next ddata_wr is accepted in the cycle busy first reads 0.
- Simultaneous ddata_wr and daddr_wr cannot occur, because the JTAG IR selects one register. If both are asserted, daddr_wr takes priority and ddata_wr is dropped.

## Configuration
- Macro: HAD_DDC_TIMEOUT_EN.
- With the macro defined:
  - A TMO_W-bit counter clears on entry to each *_EX state and increments every cycle while in it.
  - On all-ones it aborts to IDLE, sets err and sets addr_new.
- Without the macro: no counter. The *_EX states wait for done indefinitely, and only loss of debug mode aborts.

## Structure
- The shared HAD package/define file holds:
  - the state encodings (3-bit, IDLE = 3'b000),
  - the address increment constant (8),
  - the TMO_W default.
- One sub-module, ct_had_ddc_tmo, holds the timeout counter. It is instantiated only under HAD_DDC_TIMEOUT_EN.

## Test plan
- DADDR = 0x8000_0000 then DDATA = 0x1122_3344_5566_7788, done one cycle after each req.
  - Expect three inst_req pulses in the order addr_sel, data_sel, neither.
  - Expect addr_gen once, DADDR = 0x8000_0008, err = 0.
- Second DDATA with no new DADDR: exactly two inst_req pulses (data, store), and DADDR = 0x8000_0010.
- DDATA write while in DATA_EX: err = 1, the sequence completes, err clears on the next DADDR write.
- ctrl_ddc_dbg_mode dropped in ST_EX: IDLE next cycle, no addr_gen, err = 1, and the next transfer starts with ADDR_LD.
- With HAD_DDC_TIMEOUT_EN and TMO_W = 4, withhold done in ADDR_EX: abort after 15 cycles with err = 1.
- Assert cpurst_b low during DATA_EX: all outputs 0 and state IDLE with no clock edge required.
